// File: rtl/shift_reg_8bit.sv
// Parallel-load / LSB-first right-shift register forming the SPI sender and receiver datapath.
// Optional build macro SHIFT_REG_SOUT_EN adds the S_DATA_OUT and LOAD_DONE outputs.
`timescale 1ns/1ps

module shift_reg_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] P_DATA_IN,
    input  logic             S_DATA_IN,
    input  logic             SH_LD,
`ifdef SHIFT_REG_SOUT_EN
    output logic             S_DATA_OUT,
    output logic             LOAD_DONE,
`endif
    output logic [WIDTH-1:0] P_DATA_OUT
);

    logic [WIDTH-1:0] q;

    // P_DATA_IN is only read on load edges, so X/Z on it cannot reach q while shifting.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            q <= '0;
        end else if (SH_LD) begin
            q <= {S_DATA_IN, q[WIDTH-1:1]};
        end else begin
            q <= P_DATA_IN;
        end
    end

    assign P_DATA_OUT = q;

`ifdef SHIFT_REG_SOUT_EN
    logic load_done_q;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            load_done_q <= 1'b0;
        end else begin
            load_done_q <= ~SH_LD;
        end
    end

    assign S_DATA_OUT = q[0];
    assign LOAD_DONE  = load_done_q;
`endif

endmodule

// File: tb/tb_shift_reg_8bit.sv
// Directed, table-driven bench for shift_reg_8bit including a sender/receiver loopback pair.
`timescale 1ns/1ps

module tb_shift_reg_8bit;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] p_in;
    logic       s_in;
    logic       sh_ld;
    logic [7:0] p_out;
    logic       rx_sh_ld;
    logic [7:0] rx_p_in;
    logic [7:0] rx_p_out;
`ifdef SHIFT_REG_SOUT_EN
    logic       s_out;
    logic       load_done;
    logic       rx_s_out;
    logic       rx_load_done;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    shift_reg_8bit #(.WIDTH(8)) dut (
        .CLK        (clk),
        .CLR        (clr),
        .P_DATA_IN  (p_in),
        .S_DATA_IN  (s_in),
        .SH_LD      (sh_ld),
`ifdef SHIFT_REG_SOUT_EN
        .S_DATA_OUT (s_out),
        .LOAD_DONE  (load_done),
`endif
        .P_DATA_OUT (p_out)
    );

    // Receiver peer: its serial input is the sender's outgoing bit 0.
    shift_reg_8bit #(.WIDTH(8)) rx (
        .CLK        (clk),
        .CLR        (clr),
        .P_DATA_IN  (rx_p_in),
        .S_DATA_IN  (p_out[0]),
        .SH_LD      (rx_sh_ld),
`ifdef SHIFT_REG_SOUT_EN
        .S_DATA_OUT (rx_s_out),
        .LOAD_DONE  (rx_load_done),
`endif
        .P_DATA_OUT (rx_p_out)
    );

    typedef struct {
        logic       sh_ld;
        logic [7:0] p_in;
        logic       s_in;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One rising edge, then sample 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rnd;
        logic       prev_load;

        clr      = 1'b0;
        p_in     = 8'h00;
        s_in     = 1'b0;
        sh_ld    = 1'b0;
        rx_sh_ld = 1'b1;
        rx_p_in  = 8'h00;

        // Asynchronous clear after a random load, without any clock edge.
        rnd  = 8'($urandom_range(1, 255));
        p_in = rnd;
        tick();
        chk("random_load", p_out, rnd);
        clr = 1'b1;
        #1;
        chk("async_clear", p_out, 8'h00);
        sh_ld = 1'b0;
        p_in  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("clear_hold", p_out, 8'h00);
        end
`ifdef SHIFT_REG_SOUT_EN
        chk("clear_load_done", {7'd0, load_done}, 8'h00);
`endif
        clr = 1'b0;

        // Load A5 then shift out with zeros; then shift 53 in LSB-first with X on P_DATA_IN.
        vecs.push_back('{1'b0, 8'hA5, 1'b0, 8'hA5});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 8'h52});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 8'h29});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 8'h14});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 8'h0A});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 8'h05});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 8'h02});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 8'h01});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 8'hxx, 1'b1, 8'h80});
        vecs.push_back('{1'b1, 8'hxx, 1'b1, 8'hC0});
        vecs.push_back('{1'b1, 8'hxx, 1'b0, 8'h60});
        vecs.push_back('{1'b1, 8'hxx, 1'b0, 8'h30});
        vecs.push_back('{1'b1, 8'hxx, 1'b1, 8'h98});
        vecs.push_back('{1'b1, 8'hxx, 1'b0, 8'h4C});
        vecs.push_back('{1'b1, 8'hxx, 1'b1, 8'hA6});
        vecs.push_back('{1'b1, 8'hxx, 1'b0, 8'h53});
        // Mode toggling every cycle.
        vecs.push_back('{1'b0, 8'h81, 1'b1, 8'h81});
        vecs.push_back('{1'b1, 8'h00, 1'b1, 8'hC0});
        vecs.push_back('{1'b0, 8'h7E, 1'b0, 8'h7E});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 8'hFF, 1'b1, 8'h80});

        prev_load = 1'b0;
        foreach (vecs[i]) begin
            sh_ld = vecs[i].sh_ld;
            p_in  = vecs[i].p_in;
            s_in  = vecs[i].s_in;
            tick();
            chk($sformatf("vec%0d", i), p_out, vecs[i].exp);
            if ($isunknown(p_out)) begin
                checks++;
                errors++;
                $display("FAIL vec%0d_xbits: got %b expected no X/Z", i, p_out);
            end
`ifdef SHIFT_REG_SOUT_EN
            chk($sformatf("vec%0d_sout", i), {7'd0, s_out}, {7'd0, vecs[i].exp[0]});
            chk($sformatf("vec%0d_load_done", i), {7'd0, load_done}, {7'd0, ~vecs[i].sh_ld});
`endif
            prev_load = ~vecs[i].sh_ld;
        end

        // Mid-shift clear: partial word lost, next shift starts from zero.
        sh_ld = 1'b0;
        p_in  = 8'hFF;
        tick();
        sh_ld = 1'b1;
        s_in  = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_shift_pre", p_out, 8'h1F);
        clr = 1'b1;
        #2;
        chk("mid_shift_clear", p_out, 8'h00);
        clr  = 1'b0;
        s_in = 1'b1;
        tick();
        chk("mid_shift_after", p_out, 8'h80);

        // Loopback: sender loads 3C while receiver loads 00, then both shift 8 edges.
        sh_ld    = 1'b0;
        p_in     = 8'h3C;
        rx_sh_ld = 1'b0;
        rx_p_in  = 8'h00;
        tick();
        chk("loop_tx_load", p_out, 8'h3C);
        chk("loop_rx_load", rx_p_out, 8'h00);
        sh_ld    = 1'b1;
        s_in     = 1'b0;
        rx_sh_ld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        chk("loop_rx_final", rx_p_out, 8'h3C);
        chk("loop_tx_final", p_out, 8'h00);

        if (prev_load) begin
            checks = checks + 0;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100us");
        $fatal(1, "timeout");
    end

endmodule
